dma64_rd_arbiter: RTL

- Shares one 64-bit DMA read port (read ctrl + read channel) between two requesters, client 0 and client 1, inside an accelerator tile.
- Grants are round-robin. A grant is held until every beat of the granted transfer has been delivered to the owner.
- Sits between the tile's compute engines and the DMA read interface.

---
 rtl/dma64_rd_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dma64_rd_arbiter.sv
// Round-robin arbiter sharing one 64-bit DMA read port between two clients; holds grant until all beats delivered.
// Optional statistics outputs stat_xfers/stat_stall are enabled by defining DMA64_RD_ARB_STATS_EN.
module dma64_rd_arbiter #(
    parameter int LEN_W = 32,
    parameter int IDX_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c0_ctrl_valid,
    output logic             c0_ctrl_ready,
    input  logic [IDX_W-1:0] c0_ctrl_index,
    input  logic [LEN_W-1:0] c0_ctrl_length,
    input  logic [2:0]       c0_ctrl_size,
    input  logic [5:0]       c0_ctrl_user,
    output logic             c0_chnl_valid,
    input  logic             c0_chnl_ready,
    input  logic             c1_ctrl_valid,
    output logic             c1_ctrl_ready,
    input  logic [IDX_W-1:0] c1_ctrl_index,
    input  logic [LEN_W-1:0] c1_ctrl_length,
    input  logic [2:0]       c1_ctrl_size,
    input  logic [5:0]       c1_ctrl_user,
    output logic             c1_chnl_valid,
    input  logic             c1_chnl_ready,
    output logic [63:0]      chnl_data,
    input  logic             dma_read_ctrl_ready,
    output logic             dma_read_ctrl_valid,
    output logic [IDX_W-1:0] dma_read_ctrl_data_index,
    output logic [LEN_W-1:0] dma_read_ctrl_data_length,
    output logic [2:0]       dma_read_ctrl_data_size,
    output logic [5:0]       dma_read_ctrl_data_user,
    input  logic             dma_read_chnl_valid,
    output logic             dma_read_chnl_ready,
    input  logic [63:0]      dma_read_chnl_data,
    output logic [31:0]      debug
`ifdef DMA64_RD_ARB_STATS_EN
   ,output logic [31:0]      stat_xfers,
    output logic [31:0]      stat_stall
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, CTRL = 2'd1, DATA = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ctrl_vld_q, ctrl_vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       size_q, size_d;
    logic [5:0]       user_q, user_d;

    logic             win;
    logic             accept;
    logic             routing;
    logic             owner_rdy;
    logic             beat_hs;
    logic [LEN_W-1:0] win_len;

    // Gating accept with rst keeps ctrl_ready low while reset is held.
    assign win       = (c0_ctrl_valid & c1_ctrl_valid) ? prio_q : c1_ctrl_valid;
    assign accept    = rst & (state_q == IDLE) & (c0_ctrl_valid | c1_ctrl_valid);
    assign win_len   = win ? c1_ctrl_length : c0_ctrl_length;
    assign routing   = (state_q != IDLE);
    assign owner_rdy = owner_q ? c1_chnl_ready : c0_chnl_ready;
    assign beat_hs   = dma_read_chnl_valid & dma_read_chnl_ready;

    assign c0_ctrl_ready       = accept & ~win;
    assign c1_ctrl_ready       = accept & win;
    assign dma_read_chnl_ready = routing & owner_rdy;
    assign c0_chnl_valid       = routing & ~owner_q & dma_read_chnl_valid;
    assign c1_chnl_valid       = routing & owner_q & dma_read_chnl_valid;
    assign chnl_data           = dma_read_chnl_data;

    assign dma_read_ctrl_valid       = ctrl_vld_q;
    assign dma_read_ctrl_data_index  = idx_q;
    assign dma_read_ctrl_data_length = len_q;
    assign dma_read_ctrl_data_size   = size_q;
    assign dma_read_ctrl_data_user   = user_q;
    assign debug = {28'd0, prio_q, owner_q, state_q};

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        ctrl_vld_d = ctrl_vld_q;
        idx_d      = idx_q;
        len_d      = len_q;
        size_d     = size_q;
        user_d     = user_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = win;
                    prio_d  = ~win;
                    idx_d   = win ? c1_ctrl_index : c0_ctrl_index;
                    len_d   = win_len;
                    size_d  = win ? c1_ctrl_size : c0_ctrl_size;
                    user_d  = win ? c1_ctrl_user : c0_ctrl_user;
                    // Zero-length requests are acknowledged but never reach the DMA.
                    if (win_len != '0) begin
                        ctrl_vld_d = 1'b1;
                        cnt_d      = win_len;
                        state_d    = CTRL;
                    end
                end
            end
            CTRL: begin
                if (dma_read_ctrl_ready) begin
                    ctrl_vld_d = 1'b0;
                    state_d    = DATA;
                end
            end
            default: ;
        endcase
        if (routing && beat_hs) begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
                state_d    = IDLE;
                ctrl_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            ctrl_vld_q <= 1'b0;
            idx_q      <= '0;
            len_q      <= '0;
            size_q     <= '0;
            user_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            ctrl_vld_q <= ctrl_vld_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            size_q     <= size_d;
            user_q     <= user_d;
        end
    end

`ifdef DMA64_RD_ARB_STATS_EN
    logic [15:0] xfer0_q, xfer1_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer0_q <= '0;
            xfer1_q <= '0;
            stall_q <= '0;
        end else begin
            if (c0_ctrl_ready && xfer0_q != '1) xfer0_q <= xfer0_q + 16'd1;
            if (c1_ctrl_ready && xfer1_q != '1) xfer1_q <= xfer1_q + 16'd1;
            if (routing && dma_read_chnl_valid && !owner_rdy && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_xfers = {xfer1_q, xfer0_q};
    assign stat_stall = stall_q;
`endif

endmodule
